lfsr_checker: RTL
=================

Name: lfsr_checker

Overview:
- Receive-side companion to the team's Fibonacci LFSR generator. Consumes the generator's parallel state word, one word per valid cycle.
- Self-synchronises to the sequence by hunting, verifying, then locking. Once locked, it predicts each following word independently of the received data and flags mismatches.
- Reports lock status plus word-error and bit-error statistics. Used as a built-in PRBS checker on datapaths and links driven by the generator.

Parameters:
- LENGTH, 16, LFSR word width in bits.
- TAPS, 53256 (0xD008), tap mask. Bit i set means state bit i feeds the XOR. Must equal the generator's TAPS.
- LOCK_COUNT, 4, consecutive correct predictions required in VERIFY to enter LOCKED (>=1).
- UNLOCK_COUNT, 8, consecutive mismatches in LOCKED that force return to HUNT (>=1).
- CNT_W, 32, width of the error and word counters.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous clear of word_count, err_count and bit_err_count only; lock state is kept.
- data_valid  input  1  data carries a sequence word this cycle.
- data  input  LENGTH  received LFSR state word.
- locked  output  1  high while FSM is in LOCKED.
- error  output  1  one-cycle pulse: mismatch detected in LOCKED.
- zero_seen  output  1  one-cycle pulse: all-zero word received in HUNT.
- word_count  output  CNT_W  valid words checked while LOCKED; saturating.
- err_count  output  CNT_W  mismatching words while LOCKED; saturating.
- bit_err_count  output  CNT_W  sum of popcount(data XOR expected) over mismatches; saturating.

Behaviour:
- Next-state function next(s):
  - fb = XOR over i of (s[i] AND TAPS[i]).
  - next(s) = {s[LENGTH-2:0], fb}, i.e. shift toward MSB, feedback into bit 0.
- Internal registers: exp[LENGTH-1:0], match_cnt, bad_cnt, FSM state.
- Reset: state=HUNT, exp=0, match_cnt=0, bad_cnt=0. All outputs 0.
- All outputs are registered. Each output reflects a valid word one cycle after that word is sampled.
- data_valid=0: no state, counter or exp change; error and zero_seen are 0.
- HUNT, on valid:
  - data==0: stay in HUNT, pulse zero_seen. The all-zero state is a lock-up state and is never accepted.
  - otherwise: exp<=next(data), match_cnt<=0, go to VERIFY.
- VERIFY, on valid:
  - data==exp and match_cnt+1==LOCK_COUNT: go to LOCKED, bad_cnt<=0, exp<=next(data).
  - data==exp otherwise: match_cnt++, exp<=next(data).
  - data!=exp: reseed with exp<=next(data), match_cnt<=0, stay in VERIFY. If data==0, go to HUNT instead.
  - No error pulse and no counting occur in VERIFY.
- LOCKED, on valid:
  - Always: exp<=next(exp). Prediction free-runs and is never reseeded from data, so a single corrupted word yields exactly one error.
  - Always: word_count++.
  - data==exp: bad_cnt<=0.
  - data!=exp: pulse error, err_count++, bit_err_count += popcount(data XOR exp), bad_cnt++.
  - If bad_cnt+1==UNLOCK_COUNT: go to HUNT and drop locked on the following cycle.
- Counters:
  - Saturate at all-ones; no wrap.
  - bit_err_count addition clamps to all-ones.
- clear and a counter update in the same cycle: clear wins, and the counter becomes 0, not 1.
- rst overrides clear and any data_valid.
- Reset mid-sequence: back to HUNT, full resynchronisation required.
- Gaps in data_valid are allowed in every state; no timeout.
- LOCK_COUNT=1: the first correct prediction locks.

Test Plan:
- Clean lock: after rst, feed seed 0x0001 then 0x0002, 0x0004, 0x0008, 0x0011, ... each with data_valid=1.
  - locked rises 1 cycle after the 5th word (1 seed + 4 matches).
  - error never asserts; err_count=0; word_count counts only post-lock words.
- Single-word corruption: while locked, replace one expected 0x0011 with 0x0013.
  - Exactly one error pulse; err_count=1; bit_err_count=1; locked stays 1.
  - Following words are checked correctly.
- Loss of lock: while locked, drive 8 consecutive words of 0xFFFF.
  - err_count=8 and locked falls after the 8th.
  - Resuming a clean sequence relocks after 5 words.
- Zero word: in HUNT, drive data=0x0000 for 3 valid cycles -> 3 zero_seen pulses, state stays HUNT, locked=0.
- VERIFY reseed: feed 0x0001, 0x0002, 0x0005 (bad), then the sequence from 0x000A onward.
  - No error pulse.
  - Lock occurs 4 matches after 0x0005.
- Gaps and clear: toggle data_valid randomly while locked; assert clear concurrently with a mismatch.
  - Counters read 0 after clear.
  - locked unaffected; the gaps cause no false errors.

Source files
------------

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_checker
// Description : Receive-side PRBS checker for the Fibonacci LFSR generator.
//               Hunts for a non-zero seed word, verifies LOCK_COUNT
//               consecutive predictions, then locks. While locked, the
//               prediction free-runs from its own state and never reseeds
//               from the received data, so one bad word yields one error.
//               Word, word-error and bit-error counters saturate.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               clear              - zero the three statistics counters
//               data_valid, data   - received generator state word
//               locked             - FSM is in LOCKED
//               error              - one-cycle pulse on a locked mismatch
//               zero_seen          - one-cycle pulse on an all-zero word in HUNT
//               word_count         - words checked while locked
//               err_count          - mismatching words while locked
//               bit_err_count      - total differing bits over mismatches
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int                LENGTH       = 16,
    parameter logic [LENGTH-1:0] TAPS         = LENGTH'(53256),
    parameter int                LOCK_COUNT   = 4,
    parameter int                UNLOCK_COUNT = 8,
    parameter int                CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              data_valid,
    input  logic [LENGTH-1:0] data,
    output logic              locked,
    output logic              error,
    output logic              zero_seen,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  bit_err_count
);

    // Run counters only ever hold 0 .. COUNT-1: reaching COUNT causes the
    // state transition instead of being stored.
    localparam int MW = (LOCK_COUNT   > 1) ? $clog2(LOCK_COUNT)   : 1;
    localparam int BW = (UNLOCK_COUNT > 1) ? $clog2(UNLOCK_COUNT) : 1;
    localparam logic [MW-1:0] C_LOCK_LAST   = MW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0] C_UNLOCK_LAST = BW'(UNLOCK_COUNT - 1);

    // Bit-error accumulation is done one bit wider than the larger operand
    // so the carry out reveals overflow and the result can clamp.
    localparam int PW = $clog2(LENGTH + 1);
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            r_state;
    logic [LENGTH-1:0] r_exp;
    logic [MW-1:0]     r_match_cnt;
    logic [BW-1:0]     r_bad_cnt;

    logic              w_hit;
    logic              w_check;
    logic [LENGTH-1:0] w_diff;
    logic [PW-1:0]     w_pop;
    logic [SW-1:0]     w_bit_sum;
    logic [CNT_W-1:0]  w_bit_next;

    function automatic logic [LENGTH-1:0] lfsr_next(input logic [LENGTH-1:0] s);
        return {s[LENGTH-2:0], ^(s & TAPS)};
    endfunction

    assign w_hit   = (data == r_exp);
    assign w_check = data_valid && (r_state == LOCKED);
    assign w_diff  = data ^ r_exp;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < LENGTH; i++) begin
            w_pop = w_pop + PW'(w_diff[i]);
        end
    end

    assign w_bit_sum  = SW'(bit_err_count) + SW'(w_pop);
    assign w_bit_next = (w_bit_sum > SW'(C_CNT_MAX)) ? C_CNT_MAX : w_bit_sum[CNT_W-1:0];

    // ------------------------------------------------------------------
    // Synchronisation FSM with registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HUNT;
            r_exp       <= '0;
            r_match_cnt <= '0;
            r_bad_cnt   <= '0;
            locked      <= 1'b0;
            error       <= 1'b0;
            zero_seen   <= 1'b0;
        end else begin
            error     <= 1'b0;
            zero_seen <= 1'b0;
            if (data_valid) begin
                case (r_state)
                    HUNT: begin
                        if (data == '0) begin
                            // All-zero is the LFSR lock-up state; never seed from it.
                            zero_seen <= 1'b1;
                        end else begin
                            r_exp       <= lfsr_next(data);
                            r_match_cnt <= '0;
                            r_state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        // Verification always tracks the received data.
                        r_exp <= lfsr_next(data);
                        if (w_hit) begin
                            if (r_match_cnt == C_LOCK_LAST) begin
                                r_state   <= LOCKED;
                                r_bad_cnt <= '0;
                                locked    <= 1'b1;
                            end else begin
                                r_match_cnt <= r_match_cnt + MW'(1);
                            end
                        end else begin
                            r_match_cnt <= '0;
                            if (data == '0) begin
                                r_state <= HUNT;
                            end
                        end
                    end
                    LOCKED: begin
                        // Free-running prediction, independent of data.
                        r_exp <= lfsr_next(r_exp);
                        if (w_hit) begin
                            r_bad_cnt <= '0;
                        end else begin
                            error <= 1'b1;
                            if (r_bad_cnt == C_UNLOCK_LAST) begin
                                r_state <= HUNT;
                                locked  <= 1'b0;
                            end else begin
                                r_bad_cnt <= r_bad_cnt + BW'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= HUNT;
                        locked  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating statistics; clear takes priority over any update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word_count    <= '0;
            err_count     <= '0;
            bit_err_count <= '0;
        end else if (w_check) begin
            if (word_count != C_CNT_MAX) begin
                word_count <= word_count + CNT_W'(1);
            end
            if (!w_hit) begin
                if (err_count != C_CNT_MAX) begin
                    err_count <= err_count + CNT_W'(1);
                end
                bit_err_count <= w_bit_next;
            end
        end
    end

endmodule
`default_nettype wire
